// File: rtl/vec_mem_sequencer.sv
// Multi-beat memory sequencer: splits scalar/vector loads and stores into word beats,
// stalls the pipeline until the access retires and assembles the loaded vector.
module vec_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic                    cpu_vec,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [LANES*DATA_W-1:0] cpu_wdata,
    output logic                    stall,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] rdata_vec,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic                           we_q, we_d;
    logic                           vec_q, vec_d;
    logic [ADDR_W-1:0]              base_q, base_d;
    logic [LANES-1:0][DATA_W-1:0]   wdata_q, wdata_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               rd_lane_q, rd_lane_d;
    logic                           rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]               last_idx;
    logic                           accept;

    assign accept   = (state_q == S_IDLE) && cpu_req;
    assign last_idx = vec_q ? IDX_W'(LANES - 1) : '0;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        vec_d     = vec_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        rd_lane_d = rd_lane_q;
        // A pending read is always captured this cycle; only a fresh read grant re-arms it.
        rd_pend_d = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                stall = cpu_req;
                if (cpu_req) begin
                    we_d    = cpu_we;
                    vec_d   = cpu_vec;
                    base_d  = cpu_addr & ~ADDR_W'(3);
                    wdata_d = cpu_wdata;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_q + (ADDR_W'(idx_q) << 2);
                mem_wdata = wdata_q[idx_q];
                if (mem_gnt) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (!we_q) begin
                        rd_pend_d = 1'b1;
                        rd_lane_d = idx_q;
                    end
                    if (idx_q == last_idx) begin
                        state_d = we_q ? S_DONE : S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                stall   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            vec_q     <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            rd_lane_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            vec_q     <= vec_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            rd_lane_q <= rd_lane_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // One capture register per lane; a new request clears every lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] lane_q, lane_d;

        always_comb begin
            lane_d = lane_q;
            if (accept) begin
                lane_d = '0;
            end else if (rd_pend_q && (rd_lane_q == IDX_W'(gi))) begin
                lane_d = mem_rdata;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign rdata_vec[gi*DATA_W +: DATA_W] = lane_q;
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: a transaction-level model predicts beats,
// done timing and the assembled read vector; one negedge process compares.
module tb_vec_mem_sequencer;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic                    clk;
    logic                    rst;
    logic                    cpu_req;
    logic                    cpu_we;
    logic                    cpu_vec;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [LANES*DATA_W-1:0] cpu_wdata;
    logic                    stall;
    logic                    done;
    logic [LANES*DATA_W-1:0] rdata_vec;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_gnt;
    logic [DATA_W-1:0]       mem_rdata;

    vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_vec(cpu_vec),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .stall(stall), .done(done), .rdata_vec(rdata_vec),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the current instruction (written by stimulus only)
    int          op_started = 0;
    int          op_aborted = 0;
    int          gnt_delay  = 0;
    int          exp_nb     = 0;
    logic        exp_we     = 1'b0;
    logic [31:0] exp_addr [LANES];
    logic [31:0] exp_wd   [LANES];
    logic [127:0] exp_rdata = '0;
    int          acc_cyc      = 0;
    int          exp_done_cyc = 0;
    int          op_lit       = 0;
    logic        timeout_flag = 1'b0;

    // Compare-process state
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          op_done = 0;
    int          seen_op = 0;
    int          ptr     = 0;
    int          n_log   = 0;
    logic [31:0] log_addr [8];
    logic [31:0] log_wd   [8];
    logic        rst_prev = 1'b0;
    logic        to_seen  = 1'b0;

    // Memory responder: programmable grant delay, read data = beat address one cycle later
    int          wait_cnt   = 0;
    logic        rd_pend_tb = 1'b0;
    logic [31:0] rd_addr_tb = '0;

    initial begin
        mem_gnt   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        #2;
        mem_rdata  = rd_pend_tb ? rd_addr_tb : 32'hDEAD_BEEF;
        rd_pend_tb = 1'b0;
        if (mem_req) begin
            if (wait_cnt < gnt_delay) begin
                mem_gnt  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end else begin
                mem_gnt  = 1'b1;
                wait_cnt = 0;
                if (!mem_we) begin
                    rd_pend_tb = 1'b1;
                    rd_addr_tb = mem_addr;
                end
            end
        end else begin
            mem_gnt  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic lit_checks(input int lit);
        case (lit)
            1: begin
                chk("t1_rdata", rdata_vec, {32'h10C, 32'h108, 32'h104, 32'h100});
                chk("t1_lat", cyc - acc_cyc, 6);
                chk("t1_a0", log_addr[0], 32'h100);
                chk("t1_a3", log_addr[3], 32'h10C);
            end
            2: begin
                chk("t2_lat", cyc - acc_cyc, 13);
                chk("t2_a0", log_addr[0], 32'h200);
                chk("t2_a3", log_addr[3], 32'h20C);
                chk("t2_d0", log_wd[0], 32'hA0A0_000A);
                chk("t2_d1", log_wd[1], 32'hB0B0_000B);
                chk("t2_d3", log_wd[3], 32'hD0D0_000D);
            end
            3: begin
                chk("t3_rdata", rdata_vec, {96'h0, 32'h40});
                chk("t3_lat", cyc - acc_cyc, 3);
                chk("t3_a0", log_addr[0], 32'h40);
                chk("t3_nbeats", n_log, 1);
            end
            4: begin
                chk("t4_a0", log_addr[0], 32'hFFFF_FFF8);
                chk("t4_a1", log_addr[1], 32'hFFFF_FFFC);
                chk("t4_a2", log_addr[2], 32'h0000_0000);
                chk("t4_a3", log_addr[3], 32'h0000_0004);
            end
            6: begin
                chk("t6_lat", cyc - acc_cyc, 6);
                chk("t6_rdata", rdata_vec, {32'h60C, 32'h608, 32'h604, 32'h600});
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (timeout_flag && !to_seen) begin
            to_seen = 1'b1;
            chk("done_timeout", {127'h0, done}, 128'h1);
        end
        if (rst) begin
            if (rst_prev) begin
                chk("rst_stall", {127'h0, stall}, 128'h0);
                chk("rst_done", {127'h0, done}, 128'h0);
                chk("rst_mem_req", {127'h0, mem_req}, 128'h0);
                chk("rst_mem_we", {127'h0, mem_we}, 128'h0);
                chk("rst_mem_addr", mem_addr, 128'h0);
                chk("rst_mem_wdata", mem_wdata, 128'h0);
                chk("rst_rdata_vec", rdata_vec, 128'h0);
            end
        end else begin
            if (op_started != seen_op) begin
                seen_op = op_started;
                ptr     = 0;
                n_log   = 0;
            end
            if (op_started == op_done + op_aborted) begin
                chk("idle_stall", {127'h0, stall}, {127'h0, cpu_req});
                chk("idle_mem_req", {127'h0, mem_req}, 128'h0);
                chk("idle_done", {127'h0, done}, 128'h0);
            end else begin
                if (mem_req) begin
                    if (ptr < exp_nb) begin
                        chk("beat_addr", mem_addr, exp_addr[ptr]);
                        chk("beat_we", {127'h0, mem_we}, {127'h0, exp_we});
                        if (exp_we) chk("beat_wdata", mem_wdata, exp_wd[ptr]);
                        if (mem_gnt) begin
                            log_addr[n_log] = mem_addr;
                            log_wd[n_log]   = mem_wdata;
                            n_log = n_log + 1;
                            ptr   = ptr + 1;
                        end
                    end else begin
                        chk("extra_beat", {127'h0, mem_req}, 128'h0);
                    end
                end
                if (done || cyc == exp_done_cyc) begin
                    chk("done_pulse", {127'h0, done}, 128'h1);
                    chk("done_cycle", cyc, exp_done_cyc);
                    chk("done_stall", {127'h0, stall}, 128'h0);
                    chk("done_beats", ptr, exp_nb);
                    chk("done_rdata", rdata_vec, exp_rdata);
                    lit_checks(op_lit);
                    $display("op %0d: we=%0d beats=%0d done@%0d rdata=%h",
                             op_started, exp_we, ptr, cyc, rdata_vec);
                    op_done = op_done + 1;
                end else begin
                    chk("busy_stall", {127'h0, stall}, 128'h1);
                end
            end
        end
        rst_prev = rst;
    end

    task automatic start_op(input logic we, input logic vec, input logic [31:0] addr,
                            input logic [127:0] wd, input int delay, input int lit);
        int nb;
        logic [31:0] base;
        nb   = vec ? LANES : 1;
        base = addr & ~32'h3;
        exp_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            exp_addr[i] = base + 32'(4 * i);
            exp_wd[i]   = wd[i*32 +: 32];
            if (!we && i < nb) exp_rdata[i*32 +: 32] = exp_addr[i];
        end
        exp_we       = we;
        exp_nb       = nb;
        gnt_delay    = delay;
        op_lit       = lit;
        acc_cyc      = cyc;
        exp_done_cyc = cyc + nb * (delay + 1) + 1 + (we ? 0 : 1);
        cpu_we    = we;
        cpu_vec   = vec;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        op_started = op_started + 1;
    endtask

    task automatic wait_op();
        int d0;
        d0 = op_done;
        for (int k = 0; k < 200 && op_done == d0; k++) @(posedge clk);
        #1;
        if (op_done == d0) timeout_flag = 1'b1;
    endtask

    task automatic do_op(input logic we, input logic vec, input logic [31:0] addr,
                         input logic [127:0] wd, input int delay, input int lit);
        start_op(we, vec, addr, wd, delay, lit);
        wait_op();
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_vec   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        do_op(1'b0, 1'b1, 32'h100, 128'h0, 0, 1);
        idle(2);
        do_op(1'b1, 1'b1, 32'h200,
              {32'hD0D0_000D, 32'hC0C0_000C, 32'hB0B0_000B, 32'hA0A0_000A}, 2, 2);
        idle(2);
        do_op(1'b0, 1'b0, 32'h43, 128'h0, 0, 3);
        idle(2);
        do_op(1'b0, 1'b1, 32'hFFFF_FFF8, 128'h0, 0, 4);
        idle(2);

        // Reset while the second beat of a vector load is on the bus
        start_op(1'b0, 1'b1, 32'h300, 128'h0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        cpu_req    = 1'b0;
        op_aborted = op_aborted + 1;
        idle(3);
        do_op(1'b1, 1'b0, 32'h404, {96'h0, 32'h5A5A_1234}, 0, 0);
        idle(2);

        // Back-to-back instructions with cpu_req held high throughout
        do_op(1'b1, 1'b0, 32'h500, {96'h0, 32'hCAFE_0006}, 0, 0);
        do_op(1'b0, 1'b1, 32'h600, 128'h0, 0, 6);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
